// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman codebook generator: widths and FSM encoding.
package huffman_pkg;
  localparam int SYM_W      = 3;
  localparam int MAX_LEN_W  = 4;
  localparam int NODE_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_SORT    = 3'd2,
    ST_MERGE   = 3'd3,
    ST_CODE    = 3'd4,
    ST_OUTPUT  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;
endpackage

// File: rtl/huffman_min2.sv
// Combinational selector of the two smallest active weights; ties resolve to the lowest index.
module huffman_min2
  import huffman_pkg::*;
#(
  parameter int N = 15,
  parameter int W = 5
) (
  input  logic [N*W-1:0]        weights,
  input  logic [N-1:0]          active,
  output logic [NODE_IDX_W-1:0] first_idx,
  output logic                  first_vld,
  output logic [NODE_IDX_W-1:0] second_idx,
  output logic                  second_vld
);
  logic [W-1:0] first_w;
  logic [W-1:0] second_w;

  always_comb begin
    logic [W-1:0] w;
    first_idx  = '0;
    first_vld  = 1'b0;
    second_idx = '0;
    second_vld = 1'b0;
    first_w    = '0;
    second_w   = '0;
    w          = '0;
    // Ascending scan with strict compares keeps the earlier index on equal weights.
    for (int i = 0; i < N; i++) begin
      if (active[i]) begin
        w = weights[i*W +: W];
        if (!first_vld || w < first_w) begin
          second_idx = first_idx;
          second_vld = first_vld;
          second_w   = first_w;
          first_idx  = NODE_IDX_W'(i);
          first_vld  = 1'b1;
          first_w    = w;
        end else if (!second_vld || w < second_w) begin
          second_idx = NODE_IDX_W'(i);
          second_vld = 1'b1;
          second_w   = w;
        end
      end
    end
  end
endmodule

// File: rtl/huffman_encoder_core.sv
// Collects a block of symbols, builds a Huffman tree one merge per clock and
// streams the codebook in ascending symbol order.
module huffman_encoder_core
  import huffman_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_SYMBOLS = 8,
  parameter int NUM_SAMPLES = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SYM_W-1:0]       data_in,
  input  logic                   data_enable,
  output logic [NUM_SYMBOLS-1:0] data_out_symbol,
  output logic [MAX_LEN_W-1:0]   data_out_length,
  output logic [NUM_SYMBOLS-1:0] data_out_code,
  output logic                   data_out_state,
  output logic [2:0]             out_state
);
  localparam int CNT_W     = $clog2(NUM_SAMPLES + 1);
  localparam int NUM_NODES = 2 * NUM_SYMBOLS - 1;
  localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       freq_q [NUM_SYMBOLS];
  logic [CNT_W-1:0]       freq_d [NUM_SYMBOLS];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYM_W-1:0]       sym_ptr_q, sym_ptr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [NUM_SYMBOLS-1:0] sym_out_q, sym_out_d;
  logic [MAX_LEN_W-1:0]   len_out_q, len_out_d;
  logic [NUM_SYMBOLS-1:0] code_out_q, code_out_d;
  logic                   vld_out_q, vld_out_d;

  logic [CNT_W-1:0]       weight_q [NUM_NODES];
  logic [CNT_W-1:0]       weight_d [NUM_NODES];
  logic [NODE_IDX_W-1:0]  parent_q [NUM_NODES];
  logic [NODE_IDX_W-1:0]  parent_d [NUM_NODES];
  logic [NUM_NODES-1:0]   has_par_q, has_par_d;
  logic [NUM_NODES-1:0]   bit_q, bit_d;
  logic [NUM_NODES-1:0]   active_q, active_d;
  logic [NODE_IDX_W-1:0]  next_node_q, next_node_d;

  logic [NUM_NODES*CNT_W-1:0] weight_flat;
  logic [NODE_IDX_W-1:0]      first_idx, second_idx;
  logic                       first_vld, second_vld;

  logic [MAX_LEN_W-1:0]   leaf_len  [NUM_SYMBOLS];
  logic [NUM_SYMBOLS-1:0] leaf_code [NUM_SYMBOLS];
  logic [NUM_SYMBOLS-1:0] used;
  logic                   next_found;
  logic [SYM_W-1:0]       first_sym, next_sym;

  always_comb begin
    for (int i = 0; i < NUM_NODES; i++) weight_flat[i*CNT_W +: CNT_W] = weight_q[i];
  end

  huffman_min2 #(.N(NUM_NODES), .W(CNT_W)) u_min2 (
    .weights    (weight_flat),
    .active     (active_q),
    .first_idx  (first_idx),
    .first_vld  (first_vld),
    .second_idx (second_idx),
    .second_vld (second_vld)
  );

  // Leaf-to-root walk: each step's branch bit lands one position above the previous one.
  always_comb begin
    logic [NODE_IDX_W-1:0] n;
    logic [MAX_LEN_W-1:0]  len;
    logic [NUM_SYMBOLS-1:0] code;
    n   = '0;
    len = '0;
    code = '0;
    for (int s = 0; s < NUM_SYMBOLS; s++) begin
      leaf_len[s]  = '0;
      leaf_code[s] = '0;
    end
    for (int s = 0; s < NUM_SYMBOLS; s++) begin
      n    = NODE_IDX_W'(s);
      len  = '0;
      code = '0;
      for (int k = 0; k < NUM_SYMBOLS - 1; k++) begin
        if (has_par_q[n]) begin
          code = code | (NUM_SYMBOLS'(bit_q[n]) << len);
          len  = len + MAX_LEN_W'(1);
          n    = parent_q[n];
        end
      end
      if (len == '0) begin
        leaf_len[s]  = MAX_LEN_W'(1);
        leaf_code[s] = '0;
      end else begin
        leaf_len[s]  = len;
        leaf_code[s] = code;
      end
    end
  end

  always_comb begin
    next_found = 1'b0;
    first_sym  = '0;
    next_sym   = '0;
    for (int s = 0; s < NUM_SYMBOLS; s++) used[s] = (freq_q[s] != '0);
    for (int s = NUM_SYMBOLS - 1; s >= 0; s--) begin
      if (used[s]) begin
        first_sym = SYM_W'(s);
        if (s > int'(sym_ptr_q)) begin
          next_found = 1'b1;
          next_sym   = SYM_W'(s);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    cnt_d       = cnt_q;
    sym_ptr_d   = sym_ptr_q;
    hold_d      = hold_q;
    sym_out_d   = sym_out_q;
    len_out_d   = len_out_q;
    code_out_d  = code_out_q;
    vld_out_d   = vld_out_q;
    weight_d    = weight_q;
    parent_d    = parent_q;
    has_par_d   = has_par_q;
    bit_d       = bit_q;
    active_d    = active_q;
    next_node_d = next_node_q;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (data_enable) begin
          freq_d[data_in] = freq_q[data_in] + CNT_W'(1);
          cnt_d           = cnt_q + CNT_W'(1);
          state_d         = (cnt_q == CNT_W'(NUM_SAMPLES - 1)) ? ST_SORT : ST_COLLECT;
        end
      end
      ST_SORT: begin
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
          weight_d[i] = freq_q[i];
          active_d[i] = (freq_q[i] != '0);
        end
        for (int i = NUM_SYMBOLS; i < NUM_NODES; i++) begin
          weight_d[i] = '0;
          active_d[i] = 1'b0;
        end
        for (int i = 0; i < NUM_NODES; i++) parent_d[i] = '0;
        has_par_d   = '0;
        bit_d       = '0;
        next_node_d = NODE_IDX_W'(NUM_SYMBOLS);
        state_d     = ST_MERGE;
      end
      ST_MERGE: begin
        if (first_vld && second_vld) begin
          weight_d[next_node_q]  = weight_q[first_idx] + weight_q[second_idx];
          active_d[next_node_q]  = 1'b1;
          active_d[first_idx]    = 1'b0;
          active_d[second_idx]   = 1'b0;
          parent_d[first_idx]    = next_node_q;
          parent_d[second_idx]   = next_node_q;
          has_par_d[first_idx]   = 1'b1;
          has_par_d[second_idx]  = 1'b1;
          bit_d[first_idx]       = 1'b0;
          bit_d[second_idx]      = 1'b1;
          next_node_d            = next_node_q + NODE_IDX_W'(1);
        end else begin
          state_d = ST_CODE;
        end
      end
      ST_CODE: begin
        sym_ptr_d  = first_sym;
        sym_out_d  = NUM_SYMBOLS'(1) << first_sym;
        len_out_d  = leaf_len[first_sym];
        code_out_d = leaf_code[first_sym];
        vld_out_d  = 1'b1;
        hold_d     = HOLD_W'(1);
        state_d    = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (hold_q < HOLD_W'(HOLD_CYCLES)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (next_found) begin
          sym_ptr_d  = next_sym;
          sym_out_d  = NUM_SYMBOLS'(1) << next_sym;
          len_out_d  = leaf_len[next_sym];
          code_out_d = leaf_code[next_sym];
          hold_d     = HOLD_W'(1);
        end else begin
          sym_out_d  = '0;
          len_out_d  = '0;
          code_out_d = '0;
          vld_out_d  = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        for (int s = 0; s < NUM_SYMBOLS; s++) freq_d[s] = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      for (int s = 0; s < NUM_SYMBOLS; s++) freq_q[s] <= '0;
      cnt_q      <= '0;
      sym_ptr_q  <= '0;
      hold_q     <= '0;
      sym_out_q  <= '0;
      len_out_q  <= '0;
      code_out_q <= '0;
      vld_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      cnt_q      <= cnt_d;
      sym_ptr_q  <= sym_ptr_d;
      hold_q     <= hold_d;
      sym_out_q  <= sym_out_d;
      len_out_q  <= len_out_d;
      code_out_q <= code_out_d;
      vld_out_q  <= vld_out_d;
    end
  end

  // Tree storage is always rebuilt in SORT before use, so it carries no reset.
  always_ff @(posedge clock) begin
    weight_q    <= weight_d;
    parent_q    <= parent_d;
    has_par_q   <= has_par_d;
    bit_q       <= bit_d;
    active_q    <= active_d;
    next_node_q <= next_node_d;
  end

  assign data_out_symbol = sym_out_q;
  assign data_out_length = len_out_q;
  assign data_out_code   = code_out_q;
  assign data_out_state  = vld_out_q;
  assign out_state       = state_q;
endmodule

// File: tb/tb_huffman_encoder_core.sv
// Randomized block stimulus compared against a set-merging Huffman model.
module tb_huffman_encoder_core;
  localparam int HOLD = 2;
  localparam int NSAMP = 20;

  logic       clock;
  logic       reset;
  logic [2:0] data_in;
  logic       data_enable;
  logic [7:0] data_out_symbol;
  logic [3:0] data_out_length;
  logic [7:0] data_out_code;
  logic       data_out_state;
  logic [2:0] out_state;

  int n_cmp = 0;
  int n_err = 0;
  int stim_q[$];
  int m_freq[8];
  int m_len[8];
  int m_code[8];

  huffman_encoder_core #(.HOLD_CYCLES(HOLD), .NUM_SYMBOLS(8), .NUM_SAMPLES(NSAMP)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_in         (data_in),
    .data_enable     (data_enable),
    .data_out_symbol (data_out_symbol),
    .data_out_length (data_out_length),
    .data_out_code   (data_out_code),
    .data_out_state  (data_out_state),
    .out_state       (out_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Huffman by repeatedly joining the two lightest clusters; each join prepends
  // one bit (root side) to every member symbol's code.
  task automatic run_model();
    int cw[16];
    bit cact[16];
    int root[8];
    int nid, a, b;
    for (int s = 0; s < 8; s++) m_freq[s] = 0;
    for (int i = 0; i < NSAMP && i < stim_q.size(); i++) m_freq[stim_q[i]]++;
    for (int i = 0; i < 16; i++) begin cw[i] = 0; cact[i] = 0; end
    for (int s = 0; s < 8; s++) begin
      cw[s] = m_freq[s]; cact[s] = (m_freq[s] > 0); root[s] = s; m_len[s] = 0; m_code[s] = 0;
    end
    nid = 8;
    for (int step = 0; step < 8; step++) begin
      a = -1; b = -1;
      for (int i = 0; i < nid; i++) if (cact[i] && (a < 0 || cw[i] < cw[a])) a = i;
      for (int i = 0; i < nid; i++) if (cact[i] && i != a && (b < 0 || cw[i] < cw[b])) b = i;
      if (b >= 0) begin
        for (int s = 0; s < 8; s++) begin
          if (root[s] == a) begin m_len[s]++; root[s] = nid; end
          else if (root[s] == b) begin m_code[s] |= (1 << m_len[s]); m_len[s]++; root[s] = nid; end
        end
        cw[nid] = cw[a] + cw[b]; cact[nid] = 1; cact[a] = 0; cact[b] = 0; nid++;
      end
    end
    for (int s = 0; s < 8; s++) if (m_freq[s] > 0 && m_len[s] == 0) begin m_len[s] = 1; m_code[s] = 0; end
  endtask

  task automatic gen_random(input int n, input int alph);
    int base, span;
    stim_q.delete();
    base = $urandom_range(0, alph - 1);
    span = $urandom_range(1, alph);
    for (int i = 0; i < n; i++) stim_q.push_back((base + $urandom_range(0, span - 1)) % alph);
  endtask

  task automatic send_stim(input bit gaps);
    foreach (stim_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clock); data_enable = 1'b0; data_in = 3'bx;
      end
      @(negedge clock); data_enable = 1'b1; data_in = 3'(stim_q[i]);
    end
    @(negedge clock); data_enable = 1'b0; data_in = 3'bx;
  endtask

  task automatic collect_and_check(input string tag);
    int waited, cyc;
    bit seen;
    logic [7:0] os[$];
    logic [3:0] ol[$];
    logic [7:0] oc[$];
    int es[$];
    int el[$];
    int ec[$];
    run_model();
    for (int s = 0; s < 8; s++)
      if (m_freq[s] > 0)
        for (int h = 0; h < HOLD; h++) begin
          es.push_back(1 << s); el.push_back(m_len[s]); ec.push_back(m_code[s]);
        end
    waited = 0; seen = 0;
    while (!seen && waited < 60) begin
      @(negedge clock); waited++; seen = data_out_state;
    end
    check({tag, " first_entry_latency"}, 32'(seen), 32'd1);
    if (seen) begin
      cyc = 0;
      while (data_out_state && cyc < 64) begin
        os.push_back(data_out_symbol); ol.push_back(data_out_length); oc.push_back(data_out_code);
        @(negedge clock); cyc++;
      end
      check({tag, " held_entry_cycles"}, 32'(os.size()), 32'(es.size()));
      for (int i = 0; i < os.size() && i < es.size(); i++) begin
        check($sformatf("%s sym[%0d]", tag, i), 32'(os[i]), 32'(es[i]));
        check($sformatf("%s len[%0d]", tag, i), 32'(ol[i]), 32'(el[i]));
        check($sformatf("%s code[%0d]", tag, i), 32'(oc[i]), 32'(ec[i]));
      end
      check({tag, " done_state"}, 32'(out_state), 32'd6);
      check({tag, " done_symbol"}, 32'(data_out_symbol), 32'd0);
      check({tag, " done_length"}, 32'(data_out_length), 32'd0);
      check({tag, " done_code"}, 32'(data_out_code), 32'd0);
      @(negedge clock);
      check({tag, " back_to_idle"}, 32'(out_state), 32'd0);
      check({tag, " idle_valid"}, 32'(data_out_state), 32'd0);
    end
  endtask

  initial begin
    int waited;
    reset = 1'b1; data_enable = 1'b0; data_in = 3'd0;
    repeat (3) @(negedge clock);
    check("reset_state", 32'(out_state), 32'd0);
    check("reset_valid", 32'(data_out_state), 32'd0);
    check("reset_symbol", 32'(data_out_symbol), 32'd0);
    check("reset_length", 32'(data_out_length), 32'd0);
    check("reset_code", 32'(data_out_code), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single distinct symbol.
    stim_q.delete();
    for (int i = 0; i < NSAMP; i++) stim_q.push_back(5);
    send_stim(1'b0);
    collect_and_check("single_sym5");

    // Skewed three-symbol block.
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(0);
    for (int i = 0; i < 5; i++) begin stim_q.push_back(1); stim_q.push_back(2); end
    send_stim(1'b0);
    collect_and_check("three_sym");

    // Four equal frequencies.
    stim_q.delete();
    for (int s = 0; s < 4; s++) for (int i = 0; i < 5; i++) stim_q.push_back(s);
    send_stim(1'b1);
    collect_and_check("four_equal");

    // Two trailing sym7 samples after the block is full are dropped.
    gen_random(NSAMP, 7);
    stim_q.push_back(7);
    stim_q.push_back(7);
    send_stim(1'b0);
    collect_and_check("late_sym7");

    // Reset mid-collection aborts the block.
    gen_random(7, 8);
    send_stim(1'b1);
    check("mid_block_state", 32'(out_state), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_state", 32'(out_state), 32'd0);
    check("abort_valid", 32'(data_out_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    gen_random(NSAMP, 8);
    send_stim(1'b0);
    collect_and_check("after_abort");

    // Reset while the codebook is streaming.
    gen_random(NSAMP, 8);
    send_stim(1'b0);
    waited = 0;
    while (!data_out_state && waited < 60) begin @(negedge clock); waited++; end
    check("stream_started", 32'(data_out_state), 32'd1);
    reset = 1'b1;
    #1;
    check("stream_abort_state", 32'(out_state), 32'd0);
    check("stream_abort_valid", 32'(data_out_state), 32'd0);
    check("stream_abort_symbol", 32'(data_out_symbol), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Back-to-back random blocks.
    for (int blk = 0; blk < 8; blk++) begin
      gen_random(NSAMP, 8);
      send_stim(blk[0]);
      collect_and_check($sformatf("rand_blk%0d", blk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
